// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// The counter/field width is fixed here; the top-level CNT_W must match it.
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] phase;
    logic                 en;
  } ch_cfg_t;

  // A phase beyond the period cannot be reached by the counter, so start at 0.
  function automatic logic [CNT_W_DEF-1:0] load_val(input logic [CNT_W_DEF-1:0] phase,
                                                    input logic [CNT_W_DEF-1:0] div);
    return (phase <= div) ? phase : '0;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active configuration, pending flag, period counter
// and registered level/strobe outputs computed from the counter's next value.
module clk_div_ch
  import clk_div_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wr_i,
  input  ch_cfg_t wr_cfg_i,
  input  logic    sync_start_i,
  output logic    pending_o,
  output logic    div_out_o,
  output logic    tick_o
);

  localparam int W = CNT_W_DEF;

  ch_cfg_t        act_q, shd_q, nxt_cfg;
  logic           pend_q, pend_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           div_out_q, div_out_d;
  logic           tick_q, tick_d;
  logic           apply;

  always_comb begin
    apply     = pend_q & (~act_q.en | (cnt_q == act_q.div));
    nxt_cfg   = apply ? shd_q : act_q;
    cnt_d     = '0;
    if (!nxt_cfg.en) begin
      cnt_d = '0;
    end else if (apply || sync_start_i) begin
      cnt_d = load_val(nxt_cfg.phase, nxt_cfg.div);
    end else if (cnt_q == act_q.div) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Outputs track cnt_d so they line up with the counter without extra latency.
    div_out_d = nxt_cfg.en & (cnt_d < nxt_cfg.high);
    tick_d    = nxt_cfg.en & (cnt_d == '0);
    pend_d    = pend_q;
    if (wr_i) begin
      pend_d = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q     <= '0;
      shd_q     <= '0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      act_q     <= nxt_cfg;
      if (wr_i) begin
        shd_q <= wr_cfg_i;
      end
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign div_out_o = div_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config write decode plus N_CH
// independent channels that pick up new settings only at a period boundary.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic             cfg_en,
  input  logic             sync_start,
  output logic [N_CH-1:0]  div_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  logic    sel_pend;
  ch_cfg_t wr_cfg;

  // Out-of-range channel numbers match nothing, so they read as ready and are dropped.
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        sel_pend = pending[i];
      end
    end
    cfg_ready = ~rst & ~sel_pend;
  end

  always_comb begin
    wr_cfg       = '0;
    wr_cfg.div   = cfg_div;
    wr_cfg.high  = cfg_high;
    wr_cfg.phase = cfg_phase;
    wr_cfg.en    = cfg_en;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic wr;
    assign wr = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    clk_div_ch u_ch (
      .clk          (clk),
      .rst          (rst),
      .wr_i         (wr),
      .wr_cfg_i     (wr_cfg),
      .sync_start_i (sync_start),
      .pending_o    (pending[g]),
      .div_out_o    (div_out[g]),
      .tick_o       (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus randomized
// traffic compared against a period/position model of each channel.
module tb_clk_div_multi;

  localparam int N  = 5;
  localparam int CW = 3;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic          cfg_en = 1'b0;
  logic          sync_start = 1'b0;
  logic [N-1:0]  div_out, tick, pending;

  int ntests = 0;
  int nfail  = 0;

  clk_div_multi #(.N_CH(N), .CNT_W(W), .CH_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_en(cfg_en), .sync_start(sync_start), .div_out(div_out), .tick(tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: each channel is a position within its period plus a
  // configuration that is swapped in when the current period ends.
  typedef struct {
    int div;
    int high;
    int phase;
    bit en;
  } mcfg_t;

  mcfg_t m_act[N];
  mcfg_t m_shd[N];
  bit    m_pend[N];
  int    m_pos[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_act[i] = '{0, 0, 0, 1'b0};
      m_shd[i] = '{0, 0, 0, 1'b0};
      m_pend[i] = 1'b0;
      m_pos[i] = 0;
    end
  end

  always @(posedge clk) begin
    bit rdy;
    bit app;
    int per;
    rdy = !rst && !(int'(cfg_ch) < N && m_pend[cfg_ch]);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_act[i] = '{0, 0, 0, 1'b0};
        m_shd[i] = '{0, 0, 0, 1'b0};
        m_pend[i] = 1'b0;
        m_pos[i] = 0;
      end else begin
        app = m_pend[i] && (!m_act[i].en || m_pos[i] == m_act[i].div);
        per = m_act[i].div + 1;
        if (app) begin
          m_act[i] = m_shd[i];
          m_pend[i] = 1'b0;
        end
        if (!m_act[i].en) m_pos[i] = 0;
        else if (app || sync_start) m_pos[i] = (m_act[i].phase <= m_act[i].div) ? m_act[i].phase : 0;
        else m_pos[i] = (m_pos[i] + 1) % per;
        if (cfg_valid && rdy && int'(cfg_ch) == i) begin
          m_shd[i] = '{int'(cfg_div), int'(cfg_high), int'(cfg_phase), cfg_en};
          m_pend[i] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one write from a negedge, holding valid until accepted; returns at the
  // negedge after the accepting edge with valid dropped.
  task automatic wr(input int ch, input int dv, input int hi, input int ph, input bit en);
    bit done = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch = CW'(ch);
    cfg_div = W'(dv);
    cfg_high = W'(hi);
    cfg_phase = W'(ph);
    cfg_en = en;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (cfg_ready) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    ntests++;
    if (!done) begin
      nfail++;
      $display("FAIL wr_accept ch=%0d: write not accepted within 200 cycles", ch);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    ntests++;
    if (div_out !== '0 || tick !== '0 || pending !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: div_out=%b tick=%b pending=%b, required all 0", div_out, tick, pending);
    end
    ntests++;
    if (cfg_ready !== 1'b0) begin
      nfail++;
      $display("FAIL reset_ready_low: cfg_ready=%b, required 0", cfg_ready);
    end
    rst = 1'b0;
    #1;
    ntests++;
    if (cfg_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_ready_high: cfg_ready=%b, required 1", cfg_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    wr(0, 3, 2, 0, 1'b1);
    ntests++;
    if (pending[0] !== 1'b1) begin
      nfail++;
      $display("FAIL basic_pending: pending[0]=%b, required 1", pending[0]);
    end
    step();
    for (int k = 0; k < 8; k++) begin
      ntests++;
      if (div_out[0] !== ((k % 4) < 2) || tick[0] !== ((k % 4) == 0) || pending[0] !== 1'b0) begin
        nfail++;
        $display("FAIL basic_wave k=%0d: div_out=%b tick=%b pending=%b, required %b %b 0",
                 k, div_out[0], tick[0], pending[0], ((k % 4) < 2), ((k % 4) == 0));
      end
      step();
    end
  endtask

  task automatic test_div0();
    wr(2, 0, 1, 0, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      ntests++;
      if (div_out[2] !== 1'b1 || tick[2] !== 1'b1) begin
        nfail++;
        $display("FAIL div0_high k=%0d: div_out=%b tick=%b, required 1 1", k, div_out[2], tick[2]);
      end
      step();
    end
    wr(2, 0, 0, 0, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      ntests++;
      if (div_out[2] !== 1'b0 || tick[2] !== 1'b1) begin
        nfail++;
        $display("FAIL div0_zero_high k=%0d: div_out=%b tick=%b, required 0 1", k, div_out[2], tick[2]);
      end
      step();
    end
  endtask

  task automatic test_boundary_apply();
    bit exp_do[9] = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
    bit exp_pd[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    wr(1, 7, 4, 0, 1'b1);
    step();
    step();
    step();
    wr(1, 1, 1, 0, 1'b1);
    cfg_ch = CW'(1);
    #1;
    ntests++;
    if (cfg_ready !== 1'b0) begin
      nfail++;
      $display("FAIL stall_ready: cfg_ready=%b for pending ch1, required 0", cfg_ready);
    end
    for (int k = 0; k < 9; k++) begin
      ntests++;
      if (div_out[1] !== exp_do[k] || pending[1] !== exp_pd[k]) begin
        nfail++;
        $display("FAIL boundary_apply k=%0d: div_out=%b pending=%b, required %b %b",
                 k, div_out[1], pending[1], exp_do[k], exp_pd[k]);
      end
      step();
    end
  endtask

  task automatic test_sync_phase();
    int n;
    wr(0, 3, 2, 0, 1'b1);
    wr(1, 3, 2, 2, 1'b1);
    n = 0;
    while (pending !== '0 && n < 20) begin step(); n++; end
    ntests++;
    if (pending !== '0) begin
      nfail++;
      $display("FAIL sync_apply_wait: pending=%b, required 0", pending);
    end
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ntests++;
      if (div_out[0] !== ((k % 4) < 2) || tick[0] !== ((k % 4) == 0) ||
          div_out[1] !== (((k + 2) % 4) < 2) || tick[1] !== (((k + 2) % 4) == 0)) begin
        nfail++;
        $display("FAIL sync_phase k=%0d: ch0=%b%b ch1=%b%b (div_out,tick), required %b%b %b%b",
                 k, div_out[0], tick[0], div_out[1], tick[1], ((k % 4) < 2), ((k % 4) == 0),
                 (((k + 2) % 4) < 2), (((k + 2) % 4) == 0));
      end
      step();
    end
    wr(1, 3, 2, 9, 1'b1);
    n = 0;
    while (pending[1] !== 1'b0 && n < 20) begin step(); n++; end
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    ntests++;
    if (div_out[1] !== 1'b1 || tick[1] !== 1'b1 || div_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
      nfail++;
      $display("FAIL phase_clamp: ch1=%b%b ch0=%b%b (div_out,tick), required 11 11",
               div_out[1], tick[1], div_out[0], tick[0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int stalls;
    int n;
    wr(3, 9, 5, 0, 1'b1);
    step();
    cfg_valid = 1'b1;
    cfg_ch = CW'(3);
    cfg_div = W'(2); cfg_high = W'(1); cfg_phase = W'(0); cfg_en = 1'b1;
    step();
    cfg_div = W'(4); cfg_high = W'(2); cfg_phase = W'(1);
    #1;
    ntests++;
    if (cfg_ready !== 1'b0 || pending[3] !== 1'b1) begin
      nfail++;
      $display("FAIL b2b_stall: cfg_ready=%b pending=%b, required 0 1", cfg_ready, pending[3]);
    end
    stalls = 0;
    while (!cfg_ready && stalls < 30) begin
      step();
      #1;
      stalls++;
    end
    step();
    cfg_valid = 1'b0;
    ntests++;
    if (stalls < 1 || stalls > 10 || pending[3] !== 1'b1) begin
      nfail++;
      $display("FAIL b2b_accept: stalls=%0d pending=%b, required 1..10 and 1", stalls, pending[3]);
    end
    n = 0;
    while (pending[3] !== 1'b0 && n < 20) begin step(); n++; end
    for (int k = 0; k < 6; k++) begin
      ntests++;
      if (div_out[3] !== (m_act[3].en && m_pos[3] < m_act[3].high) || m_act[3].div != 4) begin
        nfail++;
        $display("FAIL b2b_second_cfg k=%0d: div_out=%b model_div=%0d, required %b and 4",
                 k, div_out[3], m_act[3].div, (m_act[3].en && m_pos[3] < m_act[3].high));
      end
      step();
    end
    cfg_valid = 1'b1;
    cfg_ch = CW'(N);
    cfg_div = W'(1); cfg_high = W'(1); cfg_en = 1'b1;
    #1;
    ntests++;
    if (cfg_ready !== 1'b1) begin
      nfail++;
      $display("FAIL oob_ready: cfg_ready=%b, required 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    ntests++;
    if (pending !== '0) begin
      nfail++;
      $display("FAIL oob_drop: pending=%b, required 0", pending);
    end
  endtask

  task automatic test_reset_midrun();
    wr(0, 5, 3, 1, 1'b1);
    ntests++;
    if (pending[0] !== 1'b1) begin
      nfail++;
      $display("FAIL rst_pre_pending: pending[0]=%b, required 1", pending[0]);
    end
    rst = 1'b1;
    step();
    ntests++;
    if (div_out !== '0 || tick !== '0 || pending !== '0 || cfg_ready !== 1'b0) begin
      nfail++;
      $display("FAIL rst_midrun: div_out=%b tick=%b pending=%b ready=%b, required 0 0 0 0",
               div_out, tick, pending, cfg_ready);
    end
    rst = 1'b0;
    cfg_ch = CW'(0);
    #1;
    ntests++;
    if (cfg_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rst_ready_after: cfg_ready=%b, required 1", cfg_ready);
    end
    step();
    ntests++;
    if (div_out !== '0 || pending !== '0) begin
      nfail++;
      $display("FAIL rst_no_partial: div_out=%b pending=%b, required 0 0", div_out, pending);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] e_do, e_tk, e_pd;
    bit e_rdy;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        e_do[i] = m_act[i].en && (m_pos[i] < m_act[i].high);
        e_tk[i] = m_act[i].en && (m_pos[i] == 0);
        e_pd[i] = m_pend[i];
      end
      ntests++;
      if (div_out !== e_do || tick !== e_tk || pending !== e_pd) begin
        nfail++;
        $display("FAIL rand_outputs c=%0d: div_out=%b tick=%b pending=%b, required %b %b %b",
                 c, div_out, tick, pending, e_do, e_tk, e_pd);
      end
      rst = ($urandom_range(0, 63) == 0);
      cfg_valid = $urandom_range(0, 1);
      cfg_ch = CW'($urandom_range(0, N));
      cfg_div = W'($urandom_range(0, 7));
      cfg_high = W'($urandom_range(0, 9));
      cfg_phase = W'($urandom_range(0, 9));
      cfg_en = ($urandom_range(0, 5) != 0);
      sync_start = ($urandom_range(0, 15) == 0);
      #1;
      e_rdy = !rst && !(int'(cfg_ch) < N && m_pend[cfg_ch]);
      ntests++;
      if (cfg_ready !== e_rdy) begin
        nfail++;
        $display("FAIL rand_ready c=%0d: cfg_ready=%b, required %b", c, cfg_ready, e_rdy);
      end
      step();
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    sync_start = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_div0();
    test_boundary_apply();
    test_sync_phase();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
